// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: PC register and IF/ID pipeline register with stall, branch redirect and fetch counter.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic [31:0] rom_data_i,
  output logic [31:0] rom_addr_o,
  output logic        rom_ce_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        id_valid_o,
  output logic [31:0] fetch_cnt_o
);
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};
  logic [31:0] pc;
  assign rom_addr_o = pc;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pc          <= RESET_PC_ALIGNED;
      rom_ce_o    <= 1'b0;
      id_pc_o     <= 32'h0;
      id_inst_o   <= NOP_WORD;
      id_valid_o  <= 1'b0;
      fetch_cnt_o <= 32'h0;
    end else begin
      rom_ce_o <= 1'b1;
      // the enabling edge only primes IF/ID with a bubble; fetching starts one edge later
      if (!rom_ce_o) begin
        pc         <= RESET_PC_ALIGNED;
        id_pc_o    <= 32'h0;
        id_inst_o  <= NOP_WORD;
        id_valid_o <= 1'b0;
      end else if (!stall_i) begin
        if (branch_flag_i) begin
          pc         <= {branch_target_i[31:2], 2'b00};
          id_pc_o    <= 32'h0;
          id_inst_o  <= NOP_WORD;
          id_valid_o <= 1'b0;
        end else begin
          pc          <= pc + 32'd4;
          id_pc_o     <= pc;
          id_inst_o   <= rom_data_i;
          id_valid_o  <= 1'b1;
          fetch_cnt_o <= fetch_cnt_o + 32'd1;
        end
      end
    end
  end
endmodule

// File: doc/inst_fetch_unit.md
INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter NOP_WORD, default 32'h0000_0000: instruction word driven into the decode stage on bubble or flush.
REQ-003 clk_i  input  1  rising-edge clock; single clock domain.
REQ-004 rst_n_i  input  1  asynchronous, active-low reset.
REQ-005 stall_i  input  1  1 = hold the PC and the IF/ID register.
REQ-006 branch_flag_i  input  1  1 = redirect fetch to branch_target_i.
REQ-007 branch_target_i  input  32  redirect address.
REQ-008 rom_data_i  input  32  instruction word returned by instruction memory (combinational, same cycle as address).
REQ-009 rom_addr_o  output  32  fetch address to instruction memory; equals the PC register.
REQ-010 rom_ce_o  output  1  instruction memory chip enable; 1 = enabled.
REQ-011 id_pc_o  output  32  PC of the instruction held in IF/ID.
REQ-012 id_inst_o  output  32  instruction held in IF/ID.
REQ-013 id_valid_o  output  1  1 = id_inst_o is a real fetched instruction.
REQ-014 fetch_cnt_o  output  32  count of instructions delivered with id_valid_o = 1.

Function
REQ-015 rom_ce_o is a register: 0 while in reset; 1 from the first rising edge after reset deassertion onward.
REQ-016 While rom_ce_o = 0, the PC holds RESET_PC.
REQ-017 When rom_ce_o = 1, stall_i = 1: PC, id_pc_o, id_inst_o, id_valid_o, and fetch_cnt_o hold their values.
REQ-018 When rom_ce_o = 1, stall_i = 0, branch_flag_i = 1: PC <= {branch_target_i[31:2], 2'b00}; id_inst_o <= NOP_WORD; id_valid_o <= 0; id_pc_o <= 0.
REQ-019 When rom_ce_o = 1, stall_i = 0, branch_flag_i = 0: PC <= PC + 4; id_pc_o <= PC; id_inst_o <= rom_data_i; id_valid_o <= 1.
REQ-020 Priority: stall_i over branch_flag_i. A branch asserted during a stall is ignored; upstream holds branch_flag_i until stall_i drops.
REQ-021 PC arithmetic is modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 with no error indication.
REQ-022 The two low bits of the PC are always 0.
REQ-023 On the edge where rom_ce_o rises from 0 to 1, the IF/ID register loads NOP_WORD with id_valid_o = 0. The first valid instruction appears one edge later.
REQ-024 fetch_cnt_o increments by 1 on every edge that loads id_valid_o <= 1. It wraps from 32'hFFFF_FFFF to 0.
REQ-025 Latency: an instruction at address A appears on id_inst_o one clock edge after rom_addr_o = A with no stall.

Reset
REQ-026 Asynchronous reset assertion immediately forces:
- PC = RESET_PC, rom_addr_o = RESET_PC
- rom_ce_o = 0
- id_pc_o = 0, id_inst_o = NOP_WORD, id_valid_o = 0
- fetch_cnt_o = 0
REQ-027 Reset asserted mid-operation, including during stall or branch, discards all state. Behaviour after release is identical to power-up per REQ-015/REQ-023.
REQ-028 No output takes an unknown value at any time after the first reset assertion.

Verification
REQ-029 Release reset with memory contents addr0 = 34011234, addr4 = 00010c00:
- edge 1: rom_ce_o = 1, rom_addr_o = 0, id_valid_o = 0
- edge 2: id_pc_o = 0, id_inst_o = 34011234, id_valid_o = 1, rom_addr_o = 4
- edge 3: id_inst_o = 00010c00, fetch_cnt_o = 2
REQ-030 With PC = 8, assert stall_i for 3 cycles: rom_addr_o stays 8, IF/ID and fetch_cnt_o unchanged. Release: next edge id_pc_o = 8, id_inst_o = 34215678.
REQ-031 With PC = 0x10, branch_flag_i = 1 and branch_target_i = 0x2E for one cycle: next edge rom_addr_o = 0x2C, id_valid_o = 0, id_inst_o = NOP_WORD. Following edge id_pc_o = 0x2C, id_inst_o = 8c050008.
REQ-032 Assert stall_i and branch_flag_i together (target 0x20) for 2 cycles: PC unchanged. Then drop stall_i with branch still high: next edge PC = 0x20, id_valid_o = 0.
REQ-033 Force PC = 32'hFFFF_FFFC with no stall: next edge rom_addr_o = 0 and id_pc_o = FFFF_FFFC. Separately, assert rst_n_i = 0 asynchronously between edges: all outputs reach reset values before the next edge.
